// File: rtl/psram_burst_responder.sv
// psram_burst_responder: memory-side model of a synchronous burst PSRAM.
// It decodes the ADV#/CE#/WE#/OE# pins and waits a fixed initial latency.
// It then streams a linear or wrapped burst into or out of an internal 16-bit word array.
// Optional feature macro: PSRAM_BYTE_LANES_EN adds the psram_ub_n/psram_lb_n byte-lane write strobes.
module psram_burst_responder #(
    parameter int MEM_AW    = 8,
    parameter int LATENCY   = 3,
    parameter int BURST_LEN = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [22:0] psram_adr,
    input  logic [15:0] psram_dat_i,
    output logic [15:0] psram_dat_o,
    output logic        psram_dat_oe,
    input  logic        psram_we_n,
    input  logic        psram_ce_n,
    input  logic        psram_adv_n,
    input  logic        psram_oe_n,
`ifdef PSRAM_BYTE_LANES_EN
    input  logic        psram_ub_n,
    input  logic        psram_lb_n,
`endif
    output logic        psram_wait
);

    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
        $error("psram_burst_responder: LATENCY must be 2..15");
    end
    if (BURST_LEN != 0 && BURST_LEN != 4 && BURST_LEN != 8 &&
        BURST_LEN != 16 && BURST_LEN != 32) begin : g_bad_burst_len
        $error("psram_burst_responder: BURST_LEN must be 0, 4, 8, 16 or 32");
    end

    // Bits of the word address that advance during a burst; the rest stay fixed.
    localparam logic [MEM_AW-1:0] WRAP_MASK =
        (BURST_LEN == 0) ? {MEM_AW{1'b1}} : MEM_AW'(BURST_LEN - 1);
    // Edge index (counted from the address edge) of the first transfer.
    // A read loads the output register one edge before the controller samples it.
    localparam logic [3:0] RD_FIRST  = 4'(LATENCY - 1);
    localparam logic [3:0] WR_FIRST  = 4'(LATENCY);
    localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE, LAT, BURST} state_t;

    state_t            state, state_nx;
    logic [3:0]        lat_cnt, lat_cnt_nx;
    logic [MEM_AW-1:0] addr, addr_nx;
    logic              wr, wr_nx;
    logic              addr_edge, xfer, mem_we, wait_nx, oe_nx, rd_load;
    logic              adr_unused;
    logic [15:0]       mem [0:(1 << MEM_AW) - 1];

    // Upper address pins are beyond the array and deliberately ignored.
    assign adr_unused = ^psram_adr[22:MEM_AW];

    function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a);
        return (a & ~WRAP_MASK) | ((a + MEM_AW'(1)) & WRAP_MASK);
    endfunction

    assign addr_edge = ~psram_ce_n & ~psram_adv_n;

    // State register plus the registered pin outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            addr         <= '0;
            wr           <= 1'b0;
            psram_dat_o  <= '0;
            psram_dat_oe <= 1'b0;
            psram_wait   <= 1'b0;
        end else begin
            state        <= state_nx;
            lat_cnt      <= lat_cnt_nx;
            addr         <= addr_nx;
            wr           <= wr_nx;
            psram_dat_oe <= oe_nx;
            psram_wait   <= wait_nx;
            if (rd_load) begin
                psram_dat_o <= mem[addr];
            end
        end
    end

    // Next-state: chip deselect wins, then a new address edge, then latency/burst progress
    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        addr_nx    = addr;
        wr_nx      = wr;
        if (psram_ce_n) begin
            state_nx = IDLE;
        end else if (addr_edge) begin
            state_nx   = LAT;
            lat_cnt_nx = 4'd1;
            addr_nx    = psram_adr[MEM_AW-1:0];
            wr_nx      = ~psram_we_n;
        end else begin
            case (state)
                LAT: begin
                    if (xfer) begin
                        state_nx = BURST;
                        addr_nx  = next_addr(addr);
                    end else begin
                        lat_cnt_nx = lat_cnt + 4'd1;
                    end
                end
                BURST:   addr_nx = next_addr(addr);
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output decode: transfer strobe, array write enable, next wait/oe values
    always_comb begin
        xfer = ~psram_ce_n & psram_adv_n &
               ((state == BURST) ||
                ((state == LAT) && (lat_cnt == (wr ? WR_FIRST : RD_FIRST))));
        mem_we  = xfer & wr & ~rst_i;
        rd_load = xfer & ~wr;
        oe_nx   = rd_load & ~psram_oe_n;
        wait_nx = ~psram_ce_n & psram_adv_n & (state == LAT) &&
                  (lat_cnt >= 4'd1) && (lat_cnt <= WAIT_LAST);
    end

    // Word array write port; contents are never reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
`ifdef PSRAM_BYTE_LANES_EN
            if (!psram_ub_n) mem[addr][15:8] <= psram_dat_i[15:8];
            if (!psram_lb_n) mem[addr][7:0]  <= psram_dat_i[7:0];
`else
            mem[addr] <= psram_dat_i;
`endif
        end
    end

endmodule

// File: tb/tb_psram_burst_responder.sv
// Bench for psram_burst_responder: two instances share the pins (linear and 4-word wrap),
// each compared against an address-sequence model and a shadow copy of its array.
module tb_psram_burst_responder;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [22:0] psram_adr;
    logic [15:0] psram_dat_i;
    logic        we_n, ce_n, adv_n, oe_n;
`ifdef PSRAM_BYTE_LANES_EN
    logic        ub_n = 1'b0, lb_n = 1'b0;
`endif
    logic [15:0] dat_o_a, dat_o_b;
    logic        oe_a, oe_b, wait_a, wait_b;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] wbuf  [0:63];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    psram_burst_responder #(.MEM_AW(8), .LATENCY(L), .BURST_LEN(0)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .psram_adr(psram_adr), .psram_dat_i(psram_dat_i),
        .psram_dat_o(dat_o_a), .psram_dat_oe(oe_a), .psram_we_n(we_n), .psram_ce_n(ce_n),
        .psram_adv_n(adv_n), .psram_oe_n(oe_n),
`ifdef PSRAM_BYTE_LANES_EN
        .psram_ub_n(ub_n), .psram_lb_n(lb_n),
`endif
        .psram_wait(wait_a));

    psram_burst_responder #(.MEM_AW(8), .LATENCY(L), .BURST_LEN(4)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .psram_adr(psram_adr), .psram_dat_i(psram_dat_i),
        .psram_dat_o(dat_o_b), .psram_dat_oe(oe_b), .psram_we_n(we_n), .psram_ce_n(ce_n),
        .psram_adv_n(adv_n), .psram_oe_n(oe_n),
`ifdef PSRAM_BYTE_LANES_EN
        .psram_ub_n(ub_n), .psram_lb_n(lb_n),
`endif
        .psram_wait(wait_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Address of word k in a burst starting at a: linear mod 256, or wrapped inside a bl-word block.
    function automatic int addr_of(input int bl, input int a, input int k);
        if (bl == 0) return (a + k) % 256;
        return (a / bl) * bl + ((a + k) % bl);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d);
`ifdef PSRAM_BYTE_LANES_EN
        return {ub_n ? old[15:8] : d[15:8], lb_n ? old[7:0] : d[7:0]};
`else
        return d + 16'd0 * old;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_wait_a"}, 32'(wait_a), 0);
        check({tag, "_wait_b"}, 32'(wait_b), 0);
        check({tag, "_oe_a"}, 32'(oe_a), 0);
        check({tag, "_oe_b"}, 32'(oe_b), 0);
    endtask

    // Called just after a negedge; drives the address edge E0 and follows the burst.
    // chain=1 leaves ce_n low so the next call's E0 aborts this burst.
    // rst_at>0 pulses rst_i on that edge (reads only) and ends the burst there.
    task automatic burst(input bit wr, input int a, input int n, input bit chain, input int rst_at);
        int   last, k, ka, kb;
        logic prev_oe_n;
        last = wr ? L + n - 1 : L + n - 2;
        ce_n = 1'b0; adv_n = 1'b0; we_n = ~wr;
        psram_adr = {15'($urandom), 8'(a)};
        oe_n = 1'($urandom); psram_dat_i = 16'($urandom);
        prev_oe_n = oe_n;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            check("wait_a", 32'(wait_a), 32'(j >= 1 && j <= L - 2));
            check("wait_b", 32'(wait_b), 32'(j >= 1 && j <= L - 2));
            check("oe_a", 32'(oe_a), 32'(!wr && j >= L - 1 && !prev_oe_n));
            check("oe_b", 32'(oe_b), 32'(!wr && j >= L - 1 && !prev_oe_n));
            if (!wr && j >= L - 1) begin
                k = j - L + 1;
                check("dat_a", 32'(dat_o_a), 32'(mem_a[addr_of(0, a, k)]));
                check("dat_b", 32'(dat_o_b), 32'(mem_b[addr_of(4, a, k)]));
            end
            if (j < last) begin
                adv_n = 1'b1; ce_n = 1'b0; we_n = 1'($urandom);
                psram_adr = 23'($urandom);
                oe_n = ($urandom_range(0, 3) == 0);
                prev_oe_n = oe_n;
                psram_dat_i = 16'($urandom);
                if (wr && j + 1 >= L) begin
                    k  = j + 1 - L;
                    ka = addr_of(0, a, k);
                    kb = addr_of(4, a, k);
                    psram_dat_i = wbuf[k];
                    mem_a[ka] = merge(mem_a[ka], wbuf[k]);
                    mem_b[kb] = merge(mem_b[kb], wbuf[k]);
                end
                if (rst_at == j + 1) begin
                    rst_i = 1'b1;
                    @(negedge clk);
                    check("rst_dat_a", 32'(dat_o_a), 0);
                    check("rst_dat_b", 32'(dat_o_b), 0);
                    check_idle("rst");
                    rst_i = 1'b0; ce_n = 1'b1; adv_n = 1'b1;
                    return;
                end
            end
        end
        if (!chain) begin
            ce_n = 1'b1; adv_n = 1'($urandom);
            @(negedge clk);
            check_idle("end");
            adv_n = 1'b1;
        end
    endtask

    initial begin
        rst_i = 1'b1; ce_n = 1'b1; adv_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        psram_adr = '0; psram_dat_i = '0;
        @(negedge clk); @(negedge clk);
        check("reset_dat_a", 32'(dat_o_a), 0);
        check("reset_dat_b", 32'(dat_o_b), 0);
        check_idle("reset");
        rst_i = 1'b0;

        // Fill every word of both arrays (4-word blocks suit both address modes).
        for (int b = 0; b < 64; b++) begin
            for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
            burst(1'b1, 4 * b, 4, 1'b0, 0);
        end

        // Linear write/read at 0x012.
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        burst(1'b1, 'h012, 4, 1'b0, 0);
        burst(1'b0, 'h012, 4, 1'b0, 0);

        // Write across the top of the array, then read it back.
        wbuf[0] = 16'h00A0; wbuf[1] = 16'h00A1; wbuf[2] = 16'h00A2;
        burst(1'b1, 'h0FE, 3, 1'b0, 0);
        burst(1'b0, 'h0FE, 3, 1'b0, 0);
        check("wrap_top_a", 32'(mem_a[0]), 32'h00A2);

        // Read that wraps inside a 4-word block on dut_b.
        burst(1'b0, 'h00E, 5, 1'b0, 0);

        // Deselect before the first write edge: nothing written.
        wbuf[0] = 16'hDEAD;
        burst(1'b1, 'h020, 0, 1'b0, 0);
        burst(1'b0, 'h020, 1, 1'b0, 0);

        // New address edge mid-burst restarts at 0x040.
        wbuf[0] = 16'h5555; wbuf[1] = 16'h6666;
        burst(1'b1, 'h030, 2, 1'b1, 0);
        burst(1'b0, 'h040, 4, 1'b0, 0);

        // Reset mid read burst, then a normal burst.
        burst(1'b0, 'h050, 6, 1'b0, L + 1);
        burst(1'b0, 'h050, 3, 1'b0, 0);

        // Deselected address strobe is ignored.
        ce_n = 1'b1; adv_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check_idle("adv_no_ce");
        adv_n = 1'b1;

`ifdef PSRAM_BYTE_LANES_EN
        wbuf[0] = 16'hFFFF;
        burst(1'b1, 'h010, 1, 1'b0, 0);
        ub_n = 1'b1; lb_n = 1'b0; wbuf[0] = 16'h1234;
        burst(1'b1, 'h010, 1, 1'b0, 0);
        ub_n = 1'b0;
        burst(1'b0, 'h010, 1, 1'b0, 0);
        check("lanes_model", 32'(mem_a['h10]), 32'hFF34);
`endif

        // Random traffic, including chained restarts.
        for (int t = 0; t < 40; t++) begin
            bit wr;
            int a, n;
            wr = 1'($urandom);
            a  = $urandom_range(0, 255);
            n  = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            burst(wr, a, n, ($urandom_range(0, 3) == 0), 0);
        end
        ce_n = 1'b1; adv_n = 1'b1;
        @(negedge clk);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
